m_pcpi_issuer: RTL and testbench
================================

// Module: m_pcpi_issuer
// PURPOSE
//  Core-side initiator for the PCPI M-extension coprocessor. Accepts one instruction/operand request
//  from the core over a valid/ready port and pre-decodes it. Legal RV32M ops are driven onto the PCPI
//  bus (valid/insn/rs1/rs2) and held until the coprocessor pulses ready; the result returns to the core.
//  Illegal ops and unresponsive coprocessors return a trap.
// PARAMETERS
//  TIMEOUT_CYCLES  16  consecutive cycles of pcpi_valid with neither pcpi_busy nor pcpi_ready before trap
//  CNT_W           5   timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clk          in   1   clock, all logic on rising edge
//  reset        in   1   synchronous, active-high reset
//  req_valid    in   1   core presents a request
//  req_ready    out  1   issuer accepts request (high only in IDLE)
//  req_insn     in   32  instruction word
//  req_rs1      in   32  rs1 operand value
//  req_rs2      in   32  rs2 operand value
//  pcpi_valid   out  1   PCPI request valid to coprocessor
//  pcpi_insn    out  32  registered instruction
//  pcpi_rs1     out  32  registered rs1
//  pcpi_rs2     out  32  registered rs2
//  pcpi_wr      in   1   coprocessor writes rd (sampled with pcpi_ready)
//  pcpi_rd      in   32  coprocessor result (sampled with pcpi_ready)
//  pcpi_busy    in   1   coprocessor has claimed the instruction
//  pcpi_ready   in   1   single-cycle completion pulse
//  rsp_valid    out  1   response to core valid
//  rsp_ready    in   1   core accepts response
//  rsp_wr       out  1   write rsp_rd to register file
//  rsp_rd       out  32  result value
//  rsp_trap     out  1   illegal instruction / timeout; rsp_wr=0 when set
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; pcpi_valid=0; rsp_valid=0; rsp_wr=0; rsp_trap=0.
//   pcpi_insn/rs1/rs2/rsp_rd=0; timeout counter=0. Reset mid-operation aborts and drops the op silently.
//  States: IDLE -> ISSUE -> RESP -> IDLE, with IDLE -> RESP for illegal ops.
//  IDLE: req_ready=1. On req_valid, register insn/rs1/rs2 and decode.
//   Legal = opcode 7'b0110011 and funct7 7'b0000001 (any funct3).
//   Legal -> ISSUE; pcpi_valid=1 from the next cycle (1-cycle issue latency).
//   Illegal -> RESP with rsp_trap=1, rsp_wr=0, rsp_rd=0; pcpi_valid never asserts.
//  ISSUE: pcpi_valid=1; insn/rs1/rs2 held stable.
//   Counter clears on any cycle with pcpi_busy=1 and increments otherwise.
//   pcpi_ready=1: capture rsp_rd<=pcpi_rd, rsp_wr<=pcpi_wr, trap=0; -> RESP.
//    pcpi_valid drops in the same cycle rsp_valid rises (ready+1).
//   Else counter==TIMEOUT_CYCLES-1 with pcpi_busy=0: -> RESP with rsp_trap=1, rsp_wr=0.
//   pcpi_ready and the timeout in the same cycle: pcpi_ready wins, no trap.
//   pcpi_ready while pcpi_valid=0 (stray pulse) is ignored in every state.
//  RESP: rsp_valid=1, outputs stable until rsp_ready=1; then -> IDLE, rsp_valid=0 next cycle.
//   No new request is accepted while in RESP (req_ready=0).
//  Throughput: at most one op in flight. Minimum round trip = 1 (issue) + coprocessor latency + 1 (resp).
// TESTING
//  MUL x3,x1,x2 (0x022081B3), rs1=6, rs2=7, model returns rd=42 after 3 cycles busy
//   -> pcpi_valid held 4 cycles with stable operands; rsp_valid, rsp_wr=1, rsp_rd=42, rsp_trap=0.
//  DIV x3,x1,x2 (0x0220C1B3), rs1=5, rs2=0
//   -> rsp_rd=0xFFFFFFFF, rsp_wr=1.
//  ADD x3,x1,x2 (0x002081B3)
//   -> pcpi_valid stays 0; rsp_valid 1 cycle after acceptance with rsp_trap=1, rsp_wr=0.
//  Legal MULH, model never busy/ready
//   -> rsp_trap=1 exactly 16 cycles after pcpi_valid rises; pcpi_valid then 0.
//  rsp_ready held low 5 cycles after completion
//   -> rsp_valid/rsp_rd stable; req_ready=0 throughout.
//  reset=1 during ISSUE
//   -> next cycle pcpi_valid=0, rsp_valid=0, req_ready=1; a following MUL completes correctly.

Source files
------------

// File: rtl/m_pcpi_issuer_if.sv
// Signal bundle between the core-side issuer, the core request/response ports and
// the PCPI coprocessor bus. "master" is the issuer, "slave" is its environment.
interface m_pcpi_issuer_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_insn;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;

  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_busy;
  logic        pcpi_ready;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_wr;
  logic [31:0] rsp_rd;
  logic        rsp_trap;

  modport master (
    input  req_valid, req_insn, req_rs1, req_rs2,
    output req_ready,
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_wr, pcpi_rd, pcpi_busy, pcpi_ready,
    output rsp_valid, rsp_wr, rsp_rd, rsp_trap,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_insn, req_rs1, req_rs2,
    input  req_ready,
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_wr, pcpi_rd, pcpi_busy, pcpi_ready,
    input  rsp_valid, rsp_wr, rsp_rd, rsp_trap,
    output rsp_ready
  );
endinterface

// File: rtl/m_pcpi_issuer.sv
// Core-side PCPI initiator for RV32M: pre-decodes one request, drives it onto the PCPI
// bus until the coprocessor completes, and returns the result or a trap to the core.
module m_pcpi_issuer #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input logic             clk,
  input logic             reset,
  m_pcpi_issuer_if.master bus_io
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e             state_q, state_d;
  logic [31:0]        insn_q, insn_d;
  logic [31:0]        rs1_q, rs1_d;
  logic [31:0]        rs2_q, rs2_d;
  logic [31:0]        rd_q, rd_d;
  logic               wr_q, wr_d;
  logic               trap_q, trap_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               legal;
  logic               timeout;

  assign legal   = (bus_io.req_insn[6:0] == 7'b0110011) &&
                   (bus_io.req_insn[31:25] == 7'b0000001);
  assign timeout = !bus_io.pcpi_busy && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    insn_d  = insn_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    trap_d  = trap_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (bus_io.req_valid) begin
          insn_d = bus_io.req_insn;
          rs1_d  = bus_io.req_rs1;
          rs2_d  = bus_io.req_rs2;
          rd_d   = '0;
          wr_d   = 1'b0;
          if (legal) begin
            trap_d  = 1'b0;
            state_d = StIssue;
          end else begin
            trap_d  = 1'b1;
            state_d = StResp;
          end
        end
      end
      StIssue: begin
        // Completion takes priority over a timeout landing in the same cycle.
        if (bus_io.pcpi_ready) begin
          rd_d    = bus_io.pcpi_rd;
          wr_d    = bus_io.pcpi_wr;
          trap_d  = 1'b0;
          state_d = StResp;
        end else if (timeout) begin
          rd_d    = '0;
          wr_d    = 1'b0;
          trap_d  = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = bus_io.pcpi_busy ? '0 : cnt_q + CNT_W'(1);
        end
      end
      StResp: begin
        if (bus_io.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      insn_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      wr_q    <= 1'b0;
      trap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      insn_q  <= insn_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      trap_q  <= trap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus_io.req_ready  = (state_q == StIdle);
  assign bus_io.pcpi_valid = (state_q == StIssue);
  assign bus_io.pcpi_insn  = insn_q;
  assign bus_io.pcpi_rs1   = rs1_q;
  assign bus_io.pcpi_rs2   = rs2_q;
  assign bus_io.rsp_valid  = (state_q == StResp);
  assign bus_io.rsp_wr     = wr_q;
  assign bus_io.rsp_rd     = rd_q;
  assign bus_io.rsp_trap   = trap_q;

endmodule

// File: tb/tb_m_pcpi_issuer.sv
// Directed bench for m_pcpi_issuer: drives core and coprocessor sides cycle by cycle
// and checks outputs 1 ns after each rising edge.
module tb_m_pcpi_issuer;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  m_pcpi_issuer_if bus ();

  m_pcpi_issuer #(
    .TIMEOUT_CYCLES(16),
    .CNT_W         (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
    bus.req_valid = 1'b1;
    bus.req_insn  = insn;
    bus.req_rs1   = rs1;
    bus.req_rs2   = rs2;
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic idle_cop();
    bus.pcpi_busy  = 1'b0;
    bus.pcpi_ready = 1'b0;
    bus.pcpi_wr    = 1'b0;
    bus.pcpi_rd    = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready);
    end
    n_checks++;
    if (bus.pcpi_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_pcpi_valid got %b want 0", bus.pcpi_valid);
    end
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_wr, bus.rsp_trap} !== 3'b000) begin
      n_fail++; $display("FAIL reset_rsp_flags got %b want 000",
                         {bus.rsp_valid, bus.rsp_wr, bus.rsp_trap});
    end
    n_checks++;
    if ({bus.pcpi_insn, bus.pcpi_rs1, bus.pcpi_rs2, bus.rsp_rd} !== 128'h0) begin
      n_fail++; $display("FAIL reset_data got %h want 0",
                         {bus.pcpi_insn, bus.pcpi_rs1, bus.pcpi_rs2, bus.rsp_rd});
    end
  endtask

  // MUL with three busy cycles then ready: pcpi_valid held for four cycles.
  task automatic test_mul();
    issue(32'h022081B3, 32'd6, 32'd7);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.pcpi_valid !== 1'b1 || bus.pcpi_insn !== 32'h022081B3 ||
          bus.pcpi_rs1 !== 32'd6 || bus.pcpi_rs2 !== 32'd7 || bus.rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL mul_issue_cyc%0d got v=%b insn=%h rs1=%0d rs2=%0d rv=%b", i,
                           bus.pcpi_valid, bus.pcpi_insn, bus.pcpi_rs1, bus.pcpi_rs2,
                           bus.rsp_valid);
      end
      if (i < 3) begin
        bus.pcpi_busy = 1'b1;
      end else begin
        bus.pcpi_busy  = 1'b0;
        bus.pcpi_ready = 1'b1;
        bus.pcpi_wr    = 1'b1;
        bus.pcpi_rd    = 32'd42;
      end
      step();
    end
    idle_cop();
    n_checks++;
    if (bus.pcpi_valid !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.rsp_wr !== 1'b1 ||
        bus.rsp_rd !== 32'd42 || bus.rsp_trap !== 1'b0 || bus.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL mul_rsp got pv=%b rv=%b wr=%b rd=%0d trap=%b rr=%b want 0 1 1 42 0 0",
                         bus.pcpi_valid, bus.rsp_valid, bus.rsp_wr, bus.rsp_rd, bus.rsp_trap,
                         bus.req_ready);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL mul_release got rv=%b rr=%b want 0 1", bus.rsp_valid,
                         bus.req_ready);
    end
  endtask

  task automatic test_div();
    issue(32'h0220C1B3, 32'd5, 32'd0);
    n_checks++;
    if (bus.pcpi_valid !== 1'b1 || bus.pcpi_insn !== 32'h0220C1B3) begin
      n_fail++; $display("FAIL div_issue got v=%b insn=%h want 1 0220c1b3", bus.pcpi_valid,
                         bus.pcpi_insn);
    end
    bus.pcpi_ready = 1'b1;
    bus.pcpi_wr    = 1'b1;
    bus.pcpi_rd    = 32'hFFFF_FFFF;
    step();
    idle_cop();
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rd !== 32'hFFFF_FFFF || bus.rsp_wr !== 1'b1 ||
        bus.rsp_trap !== 1'b0) begin
      n_fail++; $display("FAIL div_rsp got rv=%b rd=%h wr=%b trap=%b want 1 ffffffff 1 0",
                         bus.rsp_valid, bus.rsp_rd, bus.rsp_wr, bus.rsp_trap);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  // ADD is not an M op; a stray ready pulse while in RESP must not change the response.
  task automatic test_illegal();
    issue(32'h002081B3, 32'd1, 32'd2);
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.pcpi_valid !== 1'b0 || bus.rsp_trap !== 1'b1 ||
        bus.rsp_wr !== 1'b0 || bus.rsp_rd !== 32'h0) begin
      n_fail++; $display("FAIL illegal_rsp got rv=%b pv=%b trap=%b wr=%b rd=%h want 1 0 1 0 0",
                         bus.rsp_valid, bus.pcpi_valid, bus.rsp_trap, bus.rsp_wr, bus.rsp_rd);
    end
    bus.pcpi_ready = 1'b1;
    bus.pcpi_wr    = 1'b1;
    bus.pcpi_rd    = 32'd123;
    step();
    idle_cop();
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_trap !== 1'b1 || bus.rsp_wr !== 1'b0 ||
        bus.rsp_rd !== 32'h0 || bus.pcpi_valid !== 1'b0) begin
      n_fail++; $display("FAIL illegal_stray got rv=%b trap=%b wr=%b rd=%h pv=%b want 1 1 0 0 0",
                         bus.rsp_valid, bus.rsp_trap, bus.rsp_wr, bus.rsp_rd, bus.pcpi_valid);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  // MULH with a silent coprocessor traps after 16 cycles of pcpi_valid.
  task automatic test_timeout();
    int n;
    issue(32'h022091B3, 32'd3, 32'd4);
    n = 0;
    while (bus.pcpi_valid === 1'b1 && n < 40) begin
      n++;
      step();
    end
    n_checks++;
    if (n != 16) begin
      n_fail++; $display("FAIL timeout_len got %0d want 16", n);
    end
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_trap !== 1'b1 || bus.rsp_wr !== 1'b0 ||
        bus.pcpi_valid !== 1'b0) begin
      n_fail++; $display("FAIL timeout_rsp got rv=%b trap=%b wr=%b pv=%b want 1 1 0 0",
                         bus.rsp_valid, bus.rsp_trap, bus.rsp_wr, bus.pcpi_valid);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  // A busy cycle restarts the timeout window.
  task automatic test_busy_restart();
    int n;
    issue(32'h0220A1B3, 32'd1, 32'd1);
    for (int i = 0; i < 10; i++) step();
    bus.pcpi_busy = 1'b1;
    step();
    bus.pcpi_busy = 1'b0;
    n = 0;
    while (bus.pcpi_valid === 1'b1 && n < 40) begin
      n++;
      step();
    end
    n_checks++;
    if (n != 16 || bus.rsp_trap !== 1'b1) begin
      n_fail++; $display("FAIL busy_restart got len=%0d trap=%b want 16 1", n, bus.rsp_trap);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_ready_vs_timeout();
    issue(32'h0220B1B3, 32'd9, 32'd9);
    for (int i = 0; i < 15; i++) step();
    n_checks++;
    if (bus.pcpi_valid !== 1'b1) begin
      n_fail++; $display("FAIL race_still_issuing got %b want 1", bus.pcpi_valid);
    end
    bus.pcpi_ready = 1'b1;
    bus.pcpi_wr    = 1'b1;
    bus.pcpi_rd    = 32'd77;
    step();
    idle_cop();
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_trap !== 1'b0 || bus.rsp_wr !== 1'b1 ||
        bus.rsp_rd !== 32'd77) begin
      n_fail++; $display("FAIL race_rsp got rv=%b trap=%b wr=%b rd=%0d want 1 0 1 77",
                         bus.rsp_valid, bus.rsp_trap, bus.rsp_wr, bus.rsp_rd);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  // Response held 5 cycles while a new request waits; it must not be accepted.
  task automatic test_back_pressure();
    issue(32'h022081B3, 32'd2, 32'd3);
    bus.pcpi_ready = 1'b1;
    bus.pcpi_wr    = 1'b1;
    bus.pcpi_rd    = 32'h0000_1234;
    step();
    idle_cop();
    bus.req_valid = 1'b1;
    bus.req_insn  = 32'h002081B3;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rd !== 32'h0000_1234 || bus.rsp_wr !== 1'b1 ||
          bus.rsp_trap !== 1'b0 || bus.req_ready !== 1'b0) begin
        n_fail++; $display("FAIL hold_cyc%0d got rv=%b rd=%h wr=%b trap=%b rr=%b", i,
                           bus.rsp_valid, bus.rsp_rd, bus.rsp_wr, bus.rsp_trap, bus.req_ready);
      end
      step();
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL hold_release got rv=%b rr=%b want 0 1", bus.rsp_valid,
                         bus.req_ready);
    end
  endtask

  task automatic test_reset_mid_issue();
    issue(32'h022081B3, 32'd8, 32'd8);
    bus.pcpi_busy = 1'b1;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.pcpi_busy = 1'b0;
    n_checks++;
    if (bus.pcpi_valid !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset got pv=%b rv=%b rr=%b want 0 0 1", bus.pcpi_valid,
                         bus.rsp_valid, bus.req_ready);
    end
    test_mul();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_insn   = 32'h0;
    bus.req_rs1    = 32'h0;
    bus.req_rs2    = 32'h0;
    bus.rsp_ready  = 1'b0;
    idle_cop();
    test_reset();
    test_mul();
    test_div();
    test_illegal();
    test_timeout();
    test_busy_restart();
    test_ready_vs_timeout();
    test_back_pressure();
    test_reset_mid_issue();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
